icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter: INDEX_BITS, default 8, number of cache lines = 2^INDEX_BITS.
REQ-002 Parameter: WORDS_PER_LINE fixed at 4 (16-byte line), so offset = pc[3:2], index = pc[INDEX_BITS+3:4], tag = pc[31:INDEX_BITS+4].
REQ-003 clk  input  1  clock; all state changes on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ready  input  1  global enable; when 0, all state and outputs hold.
REQ-006 clear  input  1  ROB jump/flush; abandons the current fetch response.
REQ-007 fetch_req  input  1  fetch request, held high by the requester until served.
REQ-008 fetch_pc  input  32  address of the requested instruction, word aligned.
REQ-009 fetch_valid  output  1  one-cycle pulse: fetch_ins is valid.
REQ-010 fetch_ins  output  32  instruction word for the served fetch_pc.
REQ-011 mem_req  output  1  refill word request to the memory controller, held until mem_valid.
REQ-012 mem_addr  output  32  word address of the refill request.
REQ-013 mem_valid  input  1  one-cycle pulse: mem_data carries the requested word.
REQ-014 mem_data  input  32  refill data word.

Function
REQ-015 Storage: direct-mapped, per line one valid bit, one tag, four 32-bit words; the valid bit is set only after all four words of a line are written.
REQ-016 FSM states: IDLE, REFILL, RESP.
REQ-017 IDLE, fetch_req=1, clear=0, fetch_valid=0: latch fetch_pc; hit (valid and tag equal) -> fetch_valid=1 with the hit word on the next cycle, stay IDLE.
REQ-018 IDLE miss -> REFILL; refill counter k=0; mem_req=1, mem_addr={tag,index,k,2'b00} on the next cycle.
REQ-019 Hit latency is 1 cycle from the sampled request; miss latency is 4 memory round trips plus 2 cycles.
REQ-020 IDLE ignores fetch_req in any cycle where fetch_valid is 1 (requester drops its request on the following edge).
REQ-021 REFILL: on mem_valid, write mem_data to word k of the line; if k<3, k<=k+1 and mem_addr advances by 4 (mem_req stays 1); if k=3, set valid and tag, mem_req<=0, go to RESP.
REQ-022 mem_req is never deasserted while a word is outstanding; mem_addr is stable while mem_req=1 and mem_valid=0.
REQ-023 RESP: drive fetch_valid=1 with the latched-offset word of the just-filled line for one cycle, then return to IDLE, unless the drop flag is set.
REQ-024 clear in IDLE: the request in that cycle is ignored and fetch_valid<=0.
REQ-025 clear in REFILL: set the drop flag; refill continues to completion so the memory controller is never abandoned mid-transfer; the line still becomes valid.
REQ-026 RESP with the drop flag set: no fetch_valid pulse, clear the drop flag, return to IDLE.
REQ-027 clear coinciding with fetch_valid=1: the pulse already driven is not retracted; the next cycle's state follows REQ-024.
REQ-028 A new request to the line being refilled is not accepted until RESP completes; there is no hit-under-miss.
REQ-029 ready=0: FSM, counter, drop flag, arrays, and all outputs freeze; mem_valid arriving while ready=0 is the memory controller's responsibility to hold.

Reset
REQ-030 reset (sampled when ready is any value) SHALL clear all valid bits, FSM<=IDLE, k<=0, drop flag<=0, fetch_valid<=0, mem_req<=0, mem_addr<=0, fetch_ins<=0.
REQ-031 Reset mid-REFILL abandons the refill; the partially filled line remains invalid.

Verification
REQ-032 Cold miss: fetch_req=1, fetch_pc=0x0000_0008 -> mem_req with addrs 0x0,0x4,0x8,0xC in order; after the 4th mem_valid, one fetch_valid with the word returned for 0x8.
REQ-033 Hit after fill: fetch_pc=0x0000_000C -> fetch_valid exactly 1 cycle later, mem_req stays 0.
REQ-034 Conflict: fill 0x0000_0000, then request 0x0000_1000 (same index, INDEX_BITS=8) -> refill from 0x1000; afterwards 0x0000_0000 misses again.
REQ-035 Clear mid-refill: pulse clear while k=1 -> all 4 words still fetched, no fetch_valid, line valid; re-request hits in 1 cycle.
REQ-036 Held request: fetch_req stays 1 in the fetch_valid cycle -> no duplicate response or lookup.
REQ-037 ready=0 for 3 cycles during REFILL with mem_req=1 -> mem_addr, k, and outputs unchanged; operation resumes correctly.

Source files
------------

// File: rtl/icache.sv
// icache: direct-mapped instruction cache with 4-word lines and a word-serial refill port
module icache #(
    parameter int INDEX_BITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ready,
    input  logic        clear,
    input  logic        fetch_req,
    input  logic [31:0] fetch_pc,
    output logic        fetch_valid,
    output logic [31:0] fetch_ins,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_valid,
    input  logic [31:0] mem_data
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_BITS = 28 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, REFILL, RESP} state_t;

    state_t                  state;
    logic [1:0]              k;
    logic                    drop;
    logic [31:2]             pc_q;
    logic [LINES-1:0]        valid;
    logic [TAG_BITS-1:0]     tags [LINES];
    logic [31:0]             data [LINES*4];
    logic [INDEX_BITS-1:0]   req_idx;
    logic [INDEX_BITS-1:0]   fill_idx;
    logic                    hit;
    logic                    unused;

    assign req_idx  = fetch_pc[INDEX_BITS+3:4];
    assign fill_idx = pc_q[INDEX_BITS+3:4];
    assign hit      = valid[req_idx] && tags[req_idx] == fetch_pc[31:INDEX_BITS+4];
    assign unused   = ^fetch_pc[1:0];

    // Line storage: refill words land at word k of the latched line; tag written with the last word
    always_ff @(posedge clk) begin
        if (!reset && ready && state == REFILL && mem_valid) begin
            data[{fill_idx, k}] <= mem_data;
            if (k == 2'd3) tags[fill_idx] <= pc_q[31:INDEX_BITS+4];
        end
    end

    // Control FSM: lookup in IDLE, word-serial refill, then a single response (suppressed if flushed)
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            k           <= 2'd0;
            drop        <= 1'b0;
            pc_q        <= '0;
            valid       <= '0;
            fetch_valid <= 1'b0;
            fetch_ins   <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
        end else if (ready) begin
            case (state)
                IDLE: begin
                    fetch_valid <= 1'b0;
                    if (!clear && fetch_req && !fetch_valid) begin
                        pc_q <= fetch_pc[31:2];
                        if (hit) begin
                            fetch_valid <= 1'b1;
                            fetch_ins   <= data[{req_idx, fetch_pc[3:2]}];
                        end else begin
                            state    <= REFILL;
                            k        <= 2'd0;
                            mem_req  <= 1'b1;
                            mem_addr <= {fetch_pc[31:4], 4'b0000};
                        end
                    end
                end
                REFILL: begin
                    if (clear) drop <= 1'b1;
                    if (mem_valid) begin
                        if (k == 2'd3) begin
                            valid[fill_idx] <= 1'b1;
                            mem_req         <= 1'b0;
                            state           <= RESP;
                        end else begin
                            k        <= k + 2'd1;
                            mem_addr <= mem_addr + 32'd4;
                        end
                    end
                end
                RESP: begin
                    fetch_valid <= !(drop || clear);
                    if (!(drop || clear)) fetch_ins <= data[{fill_idx, pc_q[3:2]}];
                    drop  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache.sv
// tb_icache: randomized scoreboard bench for icache against a line-level cache model
module tb_icache;
    logic        clk = 0;
    logic        reset = 1;
    logic        ready = 1;
    logic        clear = 0;
    logic        fetch_req = 0;
    logic [31:0] fetch_pc = 0;
    logic        fetch_valid;
    logic [31:0] fetch_ins;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid = 0;
    logic [31:0] mem_data = 0;

    icache #(.INDEX_BITS(8)) dut (
        .clk(clk), .reset(reset), .ready(ready), .clear(clear),
        .fetch_req(fetch_req), .fetch_pc(fetch_pc),
        .fetch_valid(fetch_valid), .fetch_ins(fetch_ins),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_valid(mem_valid), .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        bit          hit;
        int          cyc;
    } exp_t;

    exp_t        resp_q[$];
    logic [31:0] addr_q[$];
    bit          m_valid [256];
    logic [19:0] m_tag [256];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          beats = 0;
    int          resp_seen = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E3779B1 + 32'h7F4A7C15;
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory controller: checks each requested address against the model's refill order, answers randomly
    always @(negedge clk) begin
        mem_valid = 0;
        if (!reset && mem_req) begin
            if (addr_q.size() == 0) check("mem_req_unexpected", {31'd0, mem_req}, 32'd0);
            else begin
                check("mem_addr", mem_addr, addr_q[0]);
                if (ready && $urandom_range(0, 2) != 0) begin
                    mem_valid = 1;
                    mem_data  = mem_word(addr_q[0]);
                    void'(addr_q.pop_front());
                    beats++;
                end
            end
        end
    end

    // Response monitor: pops the scoreboard on every fetch_valid pulse
    always @(negedge clk) begin
        if (!reset && ready && fetch_valid) begin
            resp_seen++;
            if (resp_q.size() == 0) check("fetch_valid_unexpected", {31'd0, fetch_valid}, 32'd0);
            else begin
                exp_t e;
                e = resp_q.pop_front();
                check("fetch_ins", fetch_ins, e.data);
                if (e.hit) check("hit_latency", cyc, e.cyc + 1);
            end
        end
    end

    task automatic chk_reset();
        check("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        check("rst_fetch_ins", fetch_ins, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
    endtask

    task automatic wait_resp();
        bit done = 0;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            if (fetch_valid) done = 1;
        end
        if (!done) check("resp_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        fetch_req = 0;
    endtask

    task automatic wait_beats(input int target);
        bit done = 0;
        for (int t = 0; t < 300 && !done; t++) begin
            @(posedge clk); #1;
            if (beats >= target) done = 1;
        end
        if (!done) check("beat_timeout", beats, target);
    endtask

    // mode: 0 plain, 1 clear mid-refill, 2 ready stall in refill, 3 reset mid-refill, 4 clear with request in idle
    task automatic do_fetch(input logic [31:0] pc, input int mode_in);
        exp_t e;
        int   mode = mode_in;
        int   b0 = beats;
        int   r0;
        bit   done;
        logic [7:0] idx = pc[11:4];
        bit   hit = m_valid[idx] && m_tag[idx] == pc[31:12];
        if (hit && mode != 4) mode = 0;
        e.data = mem_word(pc);
        e.hit  = hit;
        e.cyc  = cyc + (mode == 4 ? 1 : 0);
        if (!hit) begin
            for (int w = 0; w < 4; w++) addr_q.push_back({pc[31:4], w[1:0], 2'b00});
            m_valid[idx] = 1;
            m_tag[idx]   = pc[31:12];
        end
        if (mode != 1 && mode != 3) resp_q.push_back(e);
        fetch_pc  = pc;
        fetch_req = 1;
        if (mode == 4) begin
            clear = 1;
            @(posedge clk); #1;
            clear = 0;
        end
        if (mode == 1) begin
            wait_beats(b0 + 1);
            r0 = resp_seen;
            clear = 1;
            fetch_req = 0;
            @(posedge clk); #1;
            clear = 0;
            done = 0;
            for (int t = 0; t < 300 && !done; t++) begin
                @(posedge clk); #1;
                if (!mem_req) done = 1;
            end
            repeat (4) @(posedge clk);
            #1;
            check("clear_refill_words_left", addr_q.size(), 0);
            check("clear_no_response", resp_seen, r0);
        end else if (mode == 3) begin
            wait_beats(b0 + 2);
            reset = 1;
            fetch_req = 0;
            addr_q.delete();
            for (int i = 0; i < 256; i++) m_valid[i] = 0;
            @(posedge clk);
            @(negedge clk);
            chk_reset();
            @(posedge clk); #1;
            reset = 0;
        end else begin
            if (mode == 2) begin
                int b1;
                done = 0;
                for (int t = 0; t < 300 && !done; t++) begin
                    @(posedge clk); #1;
                    if (mem_req) done = 1;
                end
                ready = 0;
                b1 = beats;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_mem_req", {31'd0, mem_req}, 32'd1);
                    check("stall_fetch_valid", {31'd0, fetch_valid}, 32'd0);
                end
                check("stall_no_beats", beats, b1);
                @(posedge clk); #1;
                ready = 1;
            end
            wait_resp();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) m_valid[i] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset();
        @(posedge clk); #1;
        reset = 0;
        do_fetch(32'h0000_0008, 0);
        do_fetch(32'h0000_000C, 0);
        do_fetch(32'h0000_000C, 4);
        do_fetch(32'h0000_1000, 0);
        do_fetch(32'h0000_0000, 0);
        do_fetch(32'h0000_0040, 1);
        do_fetch(32'h0000_0048, 0);
        do_fetch(32'h0000_2084, 2);
        do_fetch(32'h0000_2088, 0);
        do_fetch(32'h0000_3000, 3);
        do_fetch(32'h0000_3000, 0);
        do_fetch(32'h0000_300C, 0);
        for (int n = 0; n < 200; n++) begin
            logic [31:0] pc;
            int r = $urandom_range(0, 15);
            pc = ($urandom_range(0, 3) << 12) | ($urandom_range(0, 7) << 4) | ($urandom_range(0, 3) << 2);
            do_fetch(pc, r == 0 ? 1 : r == 1 ? 2 : r == 2 ? 4 : r == 3 ? 3 : 0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        repeat (10) @(posedge clk);
        #1;
        check("resp_queue_drained", resp_q.size(), 0);
        check("addr_queue_drained", addr_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
